// File: rtl/j_pit_pkg.sv
// rtl/j_pit_pkg.sv - shared widths, channel indices and read-select decode for the JERRY interval timers
package j_pit_pkg;

  localparam int PIT_CW = 16;
  localparam int PIT_T1 = 0;
  localparam int PIT_T2 = 1;

  typedef enum logic [2:0] {
    RSEL_NONE = 3'd0,
    RSEL_P1   = 3'd1,
    RSEL_D1   = 3'd2,
    RSEL_P2   = 3'd3,
    RSEL_D2   = 3'd4
  } pit_rsel_e;

  // Strobes are exclusive by decode; the fixed order only keeps the mux defined.
  function automatic pit_rsel_e pit_rsel(input logic [3:0] rd);
    if (rd[0])      return RSEL_P1;
    else if (rd[1]) return RSEL_D1;
    else if (rd[2]) return RSEL_P2;
    else if (rd[3]) return RSEL_D2;
    else            return RSEL_NONE;
  endfunction

endpackage

// File: rtl/j_pit_chan.sv
// rtl/j_pit_chan.sv - one interval timer: prescaler cascaded into divider, registered tint
module j_pit_chan
  import j_pit_pkg::*;
#(
  parameter int CW    = PIT_CW,
  parameter bit RDLAT = 1'b1
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          tick,
  input  logic [CW-1:0] din,
  input  logic          pre_w,
  input  logic          div_w,
  input  logic          pre_r,
  output logic [CW-1:0] pcnt,
  output logic [CW-1:0] dcnt_rd,
  output logic          tint
);

  logic [CW-1:0] r_pre;
  logic [CW-1:0] r_div;
  logic [CW-1:0] r_pcnt;
  logic [CW-1:0] r_dcnt;
  logic [CW-1:0] r_snap;
  logic          r_armed;
  logic          r_tint;
  logic          w_count;

  // Any register write in this channel suppresses counting for that cycle.
  assign w_count = r_armed & tick & ~pre_w & ~div_w;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_pre   <= '0;
      r_div   <= '0;
      r_pcnt  <= '0;
      r_dcnt  <= '0;
      r_snap  <= '0;
      r_armed <= 1'b0;
      r_tint  <= 1'b0;
    end else begin
      r_tint <= 1'b0;
      if (pre_w) begin
        r_pre  <= din;
        r_pcnt <= din;
      end
      if (div_w) begin
        r_div   <= din;
        r_dcnt  <= din;
        r_pcnt  <= pre_w ? din : r_pre;
        r_armed <= 1'b1;
      end
      if (w_count) begin
        if (r_pcnt != '0) begin
          r_pcnt <= r_pcnt - 1'b1;
        end else begin
          r_pcnt <= r_pre;
          if (r_dcnt != '0) begin
            r_dcnt <= r_dcnt - 1'b1;
          end else begin
            r_dcnt <= r_div;
            r_tint <= 1'b1;
          end
        end
      end
      if (RDLAT && pre_r) begin
        r_snap <= r_dcnt;
      end
    end
  end

  assign pcnt    = r_pcnt;
  assign dcnt_rd = RDLAT ? r_snap : r_dcnt;
  assign tint    = r_tint;

endmodule

// File: rtl/j_pit_ctrl.sv
// rtl/j_pit_ctrl.sv - JERRY dual programmable interval timer with shared read bus
module j_pit_ctrl
  import j_pit_pkg::*;
#(
  parameter int CW    = PIT_CW,
  parameter bit RDLAT = 1'b1
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          tick,
  input  logic [CW-1:0] din,
  input  logic          pit1w,
  input  logic          pit2w,
  input  logic          pit3w,
  input  logic          pit4w,
  input  logic          pit1r,
  input  logic          pit2r,
  input  logic          pit3r,
  input  logic          pit4r,
  output logic [CW-1:0] dout,
  output logic          dout_oe,
  output logic [1:0]    tint
);

  logic [CW-1:0] w_pcnt [2];
  logic [CW-1:0] w_dcnt [2];
  logic [3:0]    w_rd;

  j_pit_chan #(.CW(CW), .RDLAT(RDLAT)) u_t1 (
    .sys_clk (sys_clk),
    .reset   (reset),
    .tick    (tick),
    .din     (din),
    .pre_w   (pit1w),
    .div_w   (pit2w),
    .pre_r   (pit1r),
    .pcnt    (w_pcnt[PIT_T1]),
    .dcnt_rd (w_dcnt[PIT_T1]),
    .tint    (tint[PIT_T1])
  );

  j_pit_chan #(.CW(CW), .RDLAT(RDLAT)) u_t2 (
    .sys_clk (sys_clk),
    .reset   (reset),
    .tick    (tick),
    .din     (din),
    .pre_w   (pit3w),
    .div_w   (pit4w),
    .pre_r   (pit3r),
    .pcnt    (w_pcnt[PIT_T2]),
    .dcnt_rd (w_dcnt[PIT_T2]),
    .tint    (tint[PIT_T2])
  );

  assign w_rd    = {pit4r, pit3r, pit2r, pit1r};
  assign dout_oe = |w_rd;

  always_comb begin
    dout = '0;
    case (pit_rsel(w_rd))
      RSEL_P1: dout = w_pcnt[PIT_T1];
      RSEL_D1: dout = w_dcnt[PIT_T1];
      RSEL_P2: dout = w_pcnt[PIT_T2];
      RSEL_D2: dout = w_dcnt[PIT_T2];
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_j_pit_ctrl.sv
// tb/tb_j_pit_ctrl.sv - self-checking bench for j_pit_ctrl with an arithmetic period model
module tb_j_pit_ctrl;
  import j_pit_pkg::*;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [15:0] din;
  logic        pit1w, pit2w, pit3w, pit4w;
  logic        pit1r, pit2r, pit3r, pit4r;
  logic [15:0] dout;
  logic        dout_oe;
  logic [1:0]  tint;

  always #5 sys_clk = ~sys_clk;

  j_pit_ctrl dut (
    .sys_clk (sys_clk), .reset (reset), .tick (tick), .din (din),
    .pit1w (pit1w), .pit2w (pit2w), .pit3w (pit3w), .pit4w (pit4w),
    .pit1r (pit1r), .pit2r (pit2r), .pit3r (pit3r), .pit4r (pit4r),
    .dout (dout), .dout_oe (dout_oe), .tint (tint)
  );

  int errors = 0;
  int checks = 0;

  // Model: an armed channel is described by its reloads and the ticks counted since arming.
  longint m_pre [2], m_div [2], m_k [2], m_up [2], m_ud [2], m_snap [2];
  bit     m_armed [2], m_dirty [2], m_snap_ok [2];
  logic [1:0]  m_tint;
  logic [15:0] obs_dout;
  logic [1:0]  obs_tint;

  typedef struct {
    bit          p1w;
    bit          p2w;
    logic [15:0] din;
    bit          tk;
    bit   [3:0]  rd;
    logic [15:0] e_dout;
    bit          e_oe;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(bit p1w, bit p2w, logic [15:0] d, bit tk, bit [3:0] rd,
                              logic [15:0] ed, bit eo);
    vec_t v;
    v.p1w = p1w; v.p2w = p2w; v.din = d; v.tk = tk; v.rd = rd; v.e_dout = ed; v.e_oe = eo;
    return v;
  endfunction

  function automatic longint mp(int c);
    return m_armed[c] ? m_pre[c] - (m_k[c] % (m_pre[c] + 1)) : m_up[c];
  endfunction

  function automatic longint md(int c);
    return m_armed[c] ? m_div[c] - ((m_k[c] / (m_pre[c] + 1)) % (m_div[c] + 1)) : m_ud[c];
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_pre[c] = 0; m_div[c] = 0; m_k[c] = 0; m_up[c] = 0; m_ud[c] = 0; m_snap[c] = 0;
      m_armed[c] = 0; m_dirty[c] = 0; m_snap_ok[c] = 1;
    end
    m_tint = 2'b00;
  endtask

  task automatic drive_idle();
    tick = 0; din = 0;
    {pit1w, pit2w, pit3w, pit4w} = 4'b0;
    {pit1r, pit2r, pit3r, pit4r} = 4'b0;
  endtask

  // One sys_clk: drive at negedge, check against the model, then advance the model at posedge.
  task automatic cycle(bit p1w, bit p2w, bit p3w, bit p4w, logic [15:0] d, bit tk, bit [3:0] rd);
    longint e;
    bit     valid;
    bit     pw, dw;
    logic [1:0] nt;
    @(negedge sys_clk);
    pit1w = p1w; pit2w = p2w; pit3w = p3w; pit4w = p4w;
    din = d; tick = tk;
    {pit4r, pit3r, pit2r, pit1r} = rd;
    #1;
    obs_dout = dout;
    obs_tint = tint;
    valid = 1;
    if (rd[0])      begin e = mp(0);     valid = !m_dirty[0]; end
    else if (rd[1]) begin e = m_snap[0]; valid = m_snap_ok[0]; end
    else if (rd[2]) begin e = mp(1);     valid = !m_dirty[1]; end
    else if (rd[3]) begin e = m_snap[1]; valid = m_snap_ok[1]; end
    else            e = 0;
    check("dout_oe", {15'd0, dout_oe}, {15'd0, |rd});
    if (valid) check("dout", dout, e[15:0]);
    check("tint", {14'd0, tint}, {14'd0, m_tint});
    @(posedge sys_clk);
    nt = 2'b00;
    for (int c = 0; c < 2; c++) begin
      pw = (c == 0) ? p1w : p3w;
      dw = (c == 0) ? p2w : p4w;
      if ((c == 0) ? rd[0] : rd[2]) begin
        m_snap[c] = md(c);
        m_snap_ok[c] = !m_dirty[c];
      end
      if (dw) begin
        if (pw) m_pre[c] = d;
        m_div[c] = d; m_armed[c] = 1; m_k[c] = 0; m_dirty[c] = 0;
      end else if (pw) begin
        m_pre[c] = d;
        if (m_armed[c]) m_dirty[c] = 1;
        else m_up[c] = d;
      end else if (m_armed[c] && tk) begin
        if (((m_k[c] + 1) % ((m_pre[c] + 1) * (m_div[c] + 1))) == 0) nt[c] = 1'b1;
        m_k[c]++;
      end
    end
    m_tint = nt;
  endtask

  initial begin
    int prev, npulse;
    bit prev_tk, tk;
    int sel, r;
    logic [15:0] d;

    drive_idle();
    reset = 1;
    model_reset();

    // Reset held: tick toggles, nothing may come out.
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      tick = i[0];
      #1;
      check("rst_tint", {14'd0, tint}, 16'd0);
      check("rst_oe", {15'd0, dout_oe}, 16'd0);
    end
    @(negedge sys_clk);
    reset = 0;
    drive_idle();

    // Directed register-level table on timer1.
    tbl[0]  = mk(0, 0, 0, 0, 4'b0001, 0, 1);
    tbl[1]  = mk(0, 0, 0, 0, 4'b0010, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0, 4'b0100, 0, 1);
    tbl[3]  = mk(0, 0, 0, 0, 4'b1000, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 4'b0000, 0, 0);
    tbl[5]  = mk(1, 0, 2, 0, 4'b0000, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 4'b0001, 2, 1);
    tbl[7]  = mk(0, 1, 3, 1, 4'b0000, 0, 0);
    tbl[8]  = mk(0, 0, 0, 1, 4'b0001, 2, 1);
    tbl[9]  = mk(0, 0, 0, 1, 4'b0010, 3, 1);
    tbl[10] = mk(0, 0, 0, 1, 4'b0001, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 4'b0010, 3, 1);
    tbl[12] = mk(0, 0, 0, 0, 4'b0001, 2, 1);
    tbl[13] = mk(0, 0, 0, 0, 4'b0010, 2, 1);
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].p1w, tbl[i].p2w, 0, 0, tbl[i].din, tbl[i].tk, tbl[i].rd);
      check($sformatf("tbl%0d_dout", i), obs_dout, tbl[i].e_dout);
      check($sformatf("tbl%0d_tint", i), {14'd0, obs_tint}, 16'd0);
    end

    // Period: PRE=2, DIV=3 -> one pulse every 12 ticks.
    cycle(1, 0, 0, 0, 2, 0, 0);
    cycle(0, 1, 0, 0, 3, 0, 0);
    prev = -1; npulse = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(0, 0, 0, 0, 0, 1, 0);
      if (obs_tint[0]) begin
        if (prev >= 0) check("period_gap", 16'(i - prev), 16'd12);
        prev = i; npulse++;
      end
      check("period_t2", {15'd0, obs_tint[1]}, 16'd0);
    end
    check("period_pulses", 16'(npulse), 16'd3);

    // Sparse tick with PRE=DIV=0.
    cycle(1, 1, 0, 0, 0, 0, 0);
    prev_tk = 0;
    for (int i = 0; i < 24; i++) begin
      tk = (i % 4 == 0);
      cycle(0, 0, 0, 0, 0, tk, 0);
      check("sparse_tint", {15'd0, obs_tint[0]}, {15'd0, prev_tk});
      prev_tk = tk;
    end

    // Coherent read: 50 ticks of PRE=1 leave dcnt = 256 - 25.
    cycle(1, 0, 0, 0, 1, 0, 0);
    cycle(0, 1, 0, 0, 16'h100, 0, 0);
    for (int i = 0; i < 50; i++) cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 4'b0001);
    check("coh_pcnt", obs_dout, 16'd1);
    for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 4'b0010);
    check("coh_snap", obs_dout, 16'd231);

    // Collision: DIV write lands on the terminal tick.
    cycle(1, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 5, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 4'b0001);
    check("coll_tint", {15'd0, obs_tint[0]}, 16'd0);
    check("coll_pcnt", obs_dout, 16'd1);
    cycle(0, 0, 0, 0, 0, 0, 4'b0010);
    check("coll_dcnt", obs_dout, 16'd5);
    for (int i = 0; i <= 12; i++) begin
      cycle(0, 0, 0, 0, 0, (i < 12), 0);
      check("coll_period", {15'd0, obs_tint[0]}, {15'd0, (i == 12)});
    end

    // Both timers: T1 (0,1), T2 (1,0) expire together every 2 ticks.
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 1, 0, 0);
    cycle(0, 1, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 0, 0, 1, 0);
      check("both_tint", {14'd0, obs_tint}, (i > 0 && i % 2 == 0) ? 16'd3 : 16'd0);
    end
    cycle(0, 0, 0, 0, 0, 1, 0);

    // Reset mid-count clears immediately.
    @(negedge sys_clk);
    drive_idle();
    tick = 1;
    reset = 1;
    #1;
    check("midrst_tint", {14'd0, tint}, 16'd0);
    pit1r = 1; #1; check("midrst_p1", dout, 16'd0);
    pit1r = 0; pit4r = 1; #1; check("midrst_d2", dout, 16'd0);
    pit4r = 0;
    @(negedge sys_clk);
    check("midrst_tint2", {14'd0, tint}, 16'd0);
    reset = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 0, 1, 4'(1 << i));
      check("postrst_rd", obs_dout, 16'd0);
      check("postrst_tint", {14'd0, obs_tint}, 16'd0);
    end

    // Randomized traffic on both channels against the model.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 11);
      d = 16'($urandom_range(0, 4));
      sel = $urandom_range(0, 5);
      tk = 1'($urandom_range(0, 1));
      cycle(r == 0, r == 0 || r == 1, r == 2, r == 2 || r == 3, d, tk,
            (sel < 4) ? 4'(1 << sel) : 4'b0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
